// File: rtl/result_checker_if.sv
// result_checker_if: halt/read-back/golden-ROM bus between the CPU harness and the result checker.
interface result_checker_if;
  logic [31:0] instr_i;
  logic [31:0] pc_i;
  logic [6:0]  mem_addr_o;
  logic [31:0] mem_data_i;
  logic [4:0]  reg_addr_o;
  logic [31:0] reg_data_i;
  logic [6:0]  gold_addr_o;
  logic [31:0] gold_data_i;
  logic        cpu_hold_o;
  logic        busy_o;
  logic        mismatch_o;
  logic [6:0]  mismatch_idx_o;
  logic [6:0]  err_cnt_o;
  logic [6:0]  first_err_o;
  logic        done_o;
  logic        pass_o;
  modport master (
    input  instr_i, pc_i, mem_data_i, reg_data_i, gold_data_i,
    output mem_addr_o, reg_addr_o, gold_addr_o, cpu_hold_o, busy_o,
           mismatch_o, mismatch_idx_o, err_cnt_o, first_err_o, done_o, pass_o
  );
  modport slave (
    output instr_i, pc_i, mem_data_i, reg_data_i, gold_data_i,
    input  mem_addr_o, reg_addr_o, gold_addr_o, cpu_hold_o, busy_o,
           mismatch_o, mismatch_idx_o, err_cnt_o, first_err_o, done_o, pass_o
  );
endinterface

// File: rtl/result_checker.sv
// result_checker: on the halt word, freezes the CPU and compares PC, data memory and registers against a golden ROM.
module result_checker #(
  parameter logic [31:0] HALT_WORD = 32'hFFFF_FFFF,
  parameter int          N_MEM     = 32,
  parameter int          N_REG     = 32
) (
  input logic             clk_i,
  input logic             rst_i,
  result_checker_if.master bus
);
  localparam logic [6:0] LAST = 7'(N_MEM + N_REG);
  localparam logic [6:0] NONE = 7'h7F;
  typedef enum logic [1:0] {IDLE, ARMED, CHK, DONE} state_t;
  state_t state_q, state_d;
  logic [6:0] idx_q, idx_d, err_cnt_q, err_cnt_d, first_err_q, first_err_d, mismatch_idx_q, mismatch_idx_d;
  logic mismatch_q, mismatch_d;
  logic chk, in_mem, in_reg, mis;
  logic [6:0] mem_off, reg_off;
  logic [31:0] dut_word;
  always_comb begin
    chk      = state_q == CHK;
    in_mem   = chk && idx_q >= 7'd1 && idx_q <= 7'(N_MEM);
    in_reg   = chk && idx_q > 7'(N_MEM);
    mem_off  = idx_q - 7'd1;
    reg_off  = idx_q - 7'(N_MEM) - 7'd1;
    dut_word = idx_q == 7'd0 ? bus.pc_i : in_mem ? bus.mem_data_i : bus.reg_data_i;
    // case-inequality so that X/Z read-back counts as a failure in simulation
    mis      = chk && (dut_word !== bus.gold_data_i);
    state_d  = state_q == IDLE  ? (bus.instr_i == HALT_WORD ? ARMED : IDLE) :
               state_q == ARMED ? CHK :
               state_q == CHK   ? (idx_q == LAST ? DONE : CHK) : DONE;
    idx_d          = chk ? idx_q + 7'd1 : 7'd0;
    mismatch_d     = mis;
    mismatch_idx_d = mis ? idx_q : mismatch_idx_q;
    err_cnt_d      = mis && err_cnt_q != 7'h7F ? err_cnt_q + 7'd1 : err_cnt_q;
    first_err_d    = mis && first_err_q == NONE ? idx_q : first_err_q;
  end
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q        <= IDLE;
      idx_q          <= 7'd0;
      mismatch_q     <= 1'b0;
      mismatch_idx_q <= 7'd0;
      err_cnt_q      <= 7'd0;
      first_err_q    <= NONE;
    end else begin
      state_q        <= state_d;
      idx_q          <= idx_d;
      mismatch_q     <= mismatch_d;
      mismatch_idx_q <= mismatch_idx_d;
      err_cnt_q      <= err_cnt_d;
      first_err_q    <= first_err_d;
    end
  end
  assign bus.gold_addr_o    = chk ? idx_q : 7'd0;
  assign bus.mem_addr_o     = in_mem ? mem_off : 7'd0;
  assign bus.reg_addr_o     = in_reg ? reg_off[4:0] : 5'd0;
  assign bus.cpu_hold_o     = state_q != IDLE;
  assign bus.busy_o         = state_q == ARMED || chk;
  assign bus.mismatch_o     = mismatch_q;
  assign bus.mismatch_idx_o = mismatch_idx_q;
  assign bus.err_cnt_o      = err_cnt_q;
  assign bus.first_err_o    = first_err_q;
  assign bus.done_o         = state_q == DONE;
  assign bus.pass_o         = state_q == DONE && err_cnt_q == 7'd0;
endmodule

// File: tb/tb_result_checker.sv
// tb_result_checker: randomized scans of PC/memory/register images checked against a golden-ROM reference model.
module tb_result_checker;
  localparam logic [31:0] HALT = 32'hFFFF_FFFF;
  logic clk = 1'b0;
  logic rst = 1'b1;
  result_checker_if bus();
  result_checker dut (.clk_i(clk), .rst_i(rst), .bus(bus));
  always #5 clk = ~clk;

  logic [31:0] gold_arr [0:126];
  logic [31:0] mem_arr  [0:31];
  logic [31:0] reg_arr  [0:31];
  logic [31:0] pc_val;
  int tests = 0;
  int fails = 0;
  int obs_q [$];
  int exp_q [$];

  always_comb begin
    bus.pc_i        = pc_val;
    bus.gold_data_i = gold_arr[bus.gold_addr_o];
    bus.mem_data_i  = mem_arr[bus.mem_addr_o[4:0]];
    bus.reg_data_i  = reg_arr[bus.reg_addr_o];
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [31:0] rnd_word();
    return ($urandom() & 32'h7FFF_FFFE) | 32'h0000_1000;
  endfunction

  task automatic fill_clean();
    for (int i = 0; i < 127; i++) gold_arr[i] = rnd_word();
    pc_val = gold_arr[0];
    for (int i = 0; i < 32; i++) begin
      mem_arr[i] = gold_arr[i + 1];
      reg_arr[i] = gold_arr[i + 33];
    end
  endtask

  task automatic build_expect();
    exp_q.delete();
    if (pc_val !== gold_arr[0]) exp_q.push_back(0);
    for (int i = 0; i < 32; i++) if (mem_arr[i] !== gold_arr[i + 1]) exp_q.push_back(i + 1);
    for (int i = 0; i < 32; i++) if (reg_arr[i] !== gold_arr[i + 33]) exp_q.push_back(i + 33);
  endtask

  task automatic do_reset();
    rst = 1'b1;
    bus.instr_i = 32'h0000_0013;
    tick();
    rst = 1'b0;
  endtask

  task automatic run_scan(output int cyc);
    obs_q.delete();
    bus.instr_i = HALT;
    tick();
    bus.instr_i = $urandom() & 32'h7FFF_FFFF;
    cyc = 0;
    while (!bus.done_o && cyc < 200) begin
      tick();
      cyc++;
      if (bus.mismatch_o) obs_q.push_back(int'(bus.mismatch_idx_o));
    end
  endtask

  task automatic check_scan(string name, int cyc);
    bit same;
    int exp_first;
    build_expect();
    exp_first = exp_q.size() ? exp_q[0] : 127;
    tests++;
    if (cyc !== 66) begin fails++; $display("FAIL %s latency got %0d want 66", name, cyc); end
    same = obs_q.size() == exp_q.size();
    if (same) for (int i = 0; i < exp_q.size(); i++) if (obs_q[i] != exp_q[i]) same = 0;
    tests++;
    if (!same) begin fails++; $display("FAIL %s pulses got %p want %p", name, obs_q, exp_q); end
    tests++;
    if (int'(bus.err_cnt_o) !== exp_q.size()) begin fails++; $display("FAIL %s err_cnt got %0d want %0d", name, bus.err_cnt_o, exp_q.size()); end
    tests++;
    if (int'(bus.first_err_o) !== exp_first) begin fails++; $display("FAIL %s first_err got %0d want %0d", name, bus.first_err_o, exp_first); end
    tests++;
    if (bus.pass_o !== (exp_q.size() == 0)) begin fails++; $display("FAIL %s pass got %b want %b", name, bus.pass_o, exp_q.size() == 0); end
    tests++;
    if ({bus.done_o, bus.busy_o, bus.cpu_hold_o} !== 3'b101) begin fails++; $display("FAIL %s done/busy/hold got %b want 101", name, {bus.done_o, bus.busy_o, bus.cpu_hold_o}); end
  endtask

  task automatic test_reset();
    do_reset();
    tests++;
    if ({bus.cpu_hold_o, bus.busy_o, bus.mismatch_o, bus.done_o, bus.pass_o} !== 5'b0) begin
      fails++; $display("FAIL reset flags got %b want 00000", {bus.cpu_hold_o, bus.busy_o, bus.mismatch_o, bus.done_o, bus.pass_o});
    end
    tests++;
    if (bus.err_cnt_o !== 7'd0 || bus.first_err_o !== 7'h7F || bus.mismatch_idx_o !== 7'd0) begin
      fails++; $display("FAIL reset counters got err=%0d first=%h idx=%0d want 0/7f/0", bus.err_cnt_o, bus.first_err_o, bus.mismatch_idx_o);
    end
    tests++;
    if ({bus.gold_addr_o, bus.mem_addr_o, bus.reg_addr_o} !== 19'd0) begin
      fails++; $display("FAIL reset addrs got %h want 0", {bus.gold_addr_o, bus.mem_addr_o, bus.reg_addr_o});
    end
  endtask

  task automatic test_clean();
    int cyc;
    fill_clean();
    do_reset();
    run_scan(cyc);
    check_scan("clean", cyc);
  endtask

  task automatic test_pc();
    int cyc;
    fill_clean();
    gold_arr[0] = 32'h0000_0040;
    pc_val = 32'h0000_0044;
    do_reset();
    run_scan(cyc);
    check_scan("pc", cyc);
  endtask

  task automatic test_mem_reg();
    int cyc;
    fill_clean();
    mem_arr[5] = ~mem_arr[5];
    reg_arr[31] = reg_arr[31] ^ 32'h0000_0100;
    do_reset();
    run_scan(cyc);
    check_scan("mem_reg", cyc);
  endtask

  task automatic test_x();
    int cyc;
    fill_clean();
    for (int i = 0; i < 32; i++) begin
      mem_arr[i] = 'x;
      reg_arr[i] = 'x;
    end
    do_reset();
    run_scan(cyc);
    check_scan("x_data", cyc);
  endtask

  task automatic test_random();
    int cyc;
    for (int n = 0; n < 6; n++) begin
      fill_clean();
      if ($urandom_range(0, 3) == 0) pc_val = pc_val ^ 32'h1;
      for (int i = 0; i < 32; i++) begin
        if ($urandom_range(0, 7) == 0) mem_arr[i] = mem_arr[i] ^ (32'h1 << $urandom_range(0, 31));
        if ($urandom_range(0, 7) == 0) reg_arr[i] = reg_arr[i] ^ (32'h1 << $urandom_range(0, 31));
      end
      do_reset();
      run_scan(cyc);
      check_scan($sformatf("random%0d", n), cyc);
    end
  endtask

  task automatic test_mid_reset();
    int cyc;
    fill_clean();
    mem_arr[2] = ~mem_arr[2];
    do_reset();
    bus.instr_i = HALT;
    tick();
    bus.instr_i = 32'h0;
    for (int i = 0; i < 21; i++) tick();
    tests++;
    if (bus.gold_addr_o !== 7'd20 || bus.err_cnt_o !== 7'd1) begin
      fails++; $display("FAIL mid_pre idx/err got %0d/%0d want 20/1", bus.gold_addr_o, bus.err_cnt_o);
    end
    rst = 1'b1;
    tick();
    rst = 1'b0;
    tests++;
    if ({bus.cpu_hold_o, bus.busy_o, bus.done_o} !== 3'b0 || bus.err_cnt_o !== 7'd0 || bus.first_err_o !== 7'h7F) begin
      fails++; $display("FAIL mid_reset hold/busy/done=%b err=%0d first=%h want 000/0/7f", {bus.cpu_hold_o, bus.busy_o, bus.done_o}, bus.err_cnt_o, bus.first_err_o);
    end
    mem_arr[2] = gold_arr[3];
    run_scan(cyc);
    check_scan("mid_reset_rescan", cyc);
  endtask

  task automatic test_done_halt();
    int cyc;
    logic [6:0] err_before;
    fill_clean();
    reg_arr[7] = ~reg_arr[7];
    do_reset();
    run_scan(cyc);
    check_scan("done_base", cyc);
    err_before = bus.err_cnt_o;
    bus.instr_i = HALT;
    for (int i = 0; i < 5; i++) begin
      tick();
      tests++;
      if (!bus.done_o || bus.busy_o || bus.mismatch_o || bus.err_cnt_o !== err_before) begin
        fails++; $display("FAIL done_halt cycle %0d done=%b busy=%b mis=%b err=%0d want 1/0/0/%0d", i, bus.done_o, bus.busy_o, bus.mismatch_o, bus.err_cnt_o, err_before);
      end
    end
  endtask

  task automatic test_halt_in_reset();
    rst = 1'b1;
    bus.instr_i = HALT;
    tick();
    rst = 1'b0;
    bus.instr_i = 32'h0;
    tick();
    tick();
    tests++;
    if ({bus.cpu_hold_o, bus.busy_o, bus.done_o} !== 3'b0) begin
      fails++; $display("FAIL halt_in_reset hold/busy/done got %b want 000", {bus.cpu_hold_o, bus.busy_o, bus.done_o});
    end
  endtask

  initial begin
    bus.instr_i = 32'h0;
    fill_clean();
    test_reset();
    test_clean();
    test_pc();
    test_mem_reg();
    test_x();
    test_random();
    test_mid_reset();
    test_done_halt();
    test_halt_in_reset();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule

// File: doc/result_checker.md
# result_checker

Self-checking end-of-program scanner for the single-cycle CPU. It watches the instruction fetched from instruction memory and detects the halt word. It then freezes the CPU and walks PC, data memory and register file one word per cycle against a golden ROM. It reports mismatch pulses, an error count and a final pass/fail, so that FPGA runs and simulation runs share one checking path.

## Interface
Parameters:
- HALT_WORD, 32'hFFFFFFFF, instruction value that ends the program
- N_MEM, 32, data-memory words checked (word indices 0..N_MEM-1)
- N_REG, 32, registers checked (0..N_REG-1); N_MEM+N_REG ≤ 126

Ports:
- clk_i  in  1  clock, all state updates on rising edge
- rst_i  in  1  synchronous, active-high reset
- instr_i  in  32  current instruction from instruction memory
- pc_i  in  32  current PC register value
- mem_addr_o  out  7  data-memory word index for read-back
- mem_data_i  in  32  data-memory word at mem_addr_o (combinational, same cycle)
- reg_addr_o  out  5  register index for read-back
- reg_data_i  in  32  register value at reg_addr_o (combinational)
- gold_addr_o  out  7  golden ROM index
- gold_data_i  in  32  golden word at gold_addr_o (combinational)
- cpu_hold_o  out  1  freezes PC / register / memory writes
- busy_o  out  1  scan in progress
- mismatch_o  out  1  one-cycle pulse per failed compare
- mismatch_idx_o  out  7  index of the compare that failed (valid with mismatch_o)
- err_cnt_o  out  7  total mismatches
- first_err_o  out  7  lowest failing index; 7'h7F if none
- done_o  out  1  scan complete, level
- pass_o  out  1  done_o && err_cnt_o==0

## Operation
- Golden ROM layout: index 0 = PC; indices 1..N_MEM = mem[idx-1]; indices N_MEM+1..N_MEM+N_REG = reg[idx-N_MEM-1]. LAST = N_MEM+N_REG.
- FSM states:
  - IDLE→ARMED when instr_i==HALT_WORD at a clock edge.
  - ARMED→CHK unconditionally; this is the settle cycle, and idx clears to 0.
  - CHK: compare at each edge, idx+1; on the edge that compares LAST, go to DONE.
  - DONE holds until rst_i.
- Read addresses are driven combinationally from idx in CHK:
  - gold_addr_o=idx.
  - mem_addr_o=idx-1 when 1≤idx≤N_MEM, else 0.
  - reg_addr_o=idx-N_MEM-1 when in register range, else 0.
- Compare selects pc_i / mem_data_i / reg_data_i by range against gold_data_i. In simulation an X or Z bit in the DUT word counts as a mismatch (case-inequality semantics).
- On a mismatch: err_cnt_o+1 (saturates at 127), mismatch_o=1 next cycle with mismatch_idx_o=idx, and first_err_o←idx if it is still 7'h7F.
- cpu_hold_o=1 in ARMED, CHK and DONE.
- busy_o=1 in ARMED and CHK.
- HALT_WORD seen in CHK or DONE: ignored.

## Timing
- Reset values: state IDLE, idx 0, all outputs 0 except first_err_o=7'h7F; address outputs 0.
- Edge E samples the halt word. From E, state=ARMED and cpu_hold_o=1.
- Edge E+1: state=CHK, idx=0.
- Edges E+2 … E+2+LAST perform the compares for idx 0..LAST. That is LAST+1 cycles, 65 at default parameters.
- Pulse timing: the compare at edge k updates err_cnt_o, mismatch_o and mismatch_idx_o visible after k. mismatch_o drops after k+1 unless k+1 also fails.
- Completion: done_o and pass_o rise after edge E+2+LAST, which is E+66 at defaults. busy_o falls on the same edge.
- Halt word at the edge rst_i is high: reset wins; the word is re-sampled on the next edge.
- rst_i mid-scan: next state IDLE, counters cleared, cpu_hold_o released. A later halt restarts a full scan.
- err_cnt_o is monotonic within a scan. first_err_o is written at most once per scan.

## Test plan
- All DUT words equal golden: halt at E -> no mismatch_o, done_o=1 and pass_o=1 after E+66, err_cnt_o=0, first_err_o=7'h7F.
- pc_i=32'h0000_0044, golden[0]=32'h0000_0040 -> single mismatch_o pulse after E+2, mismatch_idx_o=0, err_cnt_o=1, first_err_o=0, pass_o=0.
- mem[5] and reg[31] wrong -> pulses with idx 6 and 64, err_cnt_o=2, first_err_o=6.
- mem_data_i and reg_data_i all X -> err_cnt_o=64, first_err_o=1; pc correct.
- Reset asserted when idx=20 -> next cycle IDLE, err_cnt_o=0, cpu_hold_o=0. A new halt completes a clean full scan 66 cycles later.
- Halt word re-presented while in DONE -> no state change. Halt word with rst_i high -> stays IDLE.
